// File: rtl/cskip_accum32_pkg.sv
// Shared widths and FSM encoding for the carry-skip frame accumulator.
package cskip_accum32_pkg;

    localparam int DATA_W        = 32;
    localparam int CNT_W_DEFAULT = 8;
    localparam int BLK_W         = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

endpackage

// File: rtl/cskip_add32.sv
// Combinational 32-bit carry-skip adder built from 4-bit ripple blocks.
module cskip_add32
    import cskip_accum32_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              cin,
    output logic [DATA_W-1:0] sum,
    output logic              cout
);

    localparam int NBLK = DATA_W / BLK_W;

    logic [NBLK:0]       blk_c;
    logic [DATA_W-1:0]   s;
    logic                rc;
    logic                prop;

    always_comb begin
        blk_c    = '0;
        s        = '0;
        rc       = 1'b0;
        prop     = 1'b0;
        blk_c[0] = cin;
        for (int blk = 0; blk < NBLK; blk++) begin
            rc   = blk_c[blk];
            prop = 1'b1;
            for (int k = 0; k < BLK_W; k++) begin
                s[blk*BLK_W+k] = a[blk*BLK_W+k] ^ b[blk*BLK_W+k] ^ rc;
                rc   = (a[blk*BLK_W+k] & b[blk*BLK_W+k]) |
                       ((a[blk*BLK_W+k] ^ b[blk*BLK_W+k]) & rc);
                prop = prop & (a[blk*BLK_W+k] ^ b[blk*BLK_W+k]);
            end
            // a fully propagating block passes its carry-in straight through
            blk_c[blk+1] = prop ? blk_c[blk] : rc;
        end
    end

    assign sum  = s;
    assign cout = blk_c[NBLK];

endmodule

// File: rtl/cskip_accum32.sv
// Framed streaming accumulator feeding a carry-skip adder; emits sum, sticky carry and beat count.
//
// state | meaning
// IDLE  | waiting for the first beat of a frame
// ACCUM | frame in progress, adding beats to the running total
// HOLD  | result presented on the output port until accepted
module cskip_accum32
    import cskip_accum32_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_sum,
    output logic              out_carry,
    output logic [CNT_W-1:0]  out_count
);

    state_t state, state_nxt;

    logic [DATA_W-1:0] acc;
    logic              sticky;
    logic [CNT_W-1:0]  count;

    logic              in_fire;
    logic              first_beat;
    logic [DATA_W-1:0] add_a;
    logic [DATA_W-1:0] add_sum;
    logic              add_cout;
    logic              sticky_nxt;
    logic [CNT_W-1:0]  count_nxt;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = in_last ? HOLD : ACCUM;
            end
            ACCUM: begin
                in_ready = 1'b1;
                if (in_valid && in_last) state_nxt = HOLD;
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign in_fire    = in_valid & in_ready;
    assign first_beat = (state == IDLE);
    // the first beat of a frame starts from zero rather than the stale total
    assign add_a      = first_beat ? '0 : acc;

    cskip_add32 u_add (
        .a    (add_a),
        .b    (in_data),
        .cin  (1'b0),
        .sum  (add_sum),
        .cout (add_cout)
    );

    assign sticky_nxt = first_beat ? 1'b0 : (sticky | add_cout);

    always_comb begin
        count_nxt = count;
        if (first_beat)                  count_nxt = CNT_W'(1);
        else if (count != {CNT_W{1'b1}}) count_nxt = count + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= '0;
            sticky    <= 1'b0;
            count     <= '0;
            out_sum   <= '0;
            out_carry <= 1'b0;
            out_count <= '0;
        end else if (in_fire) begin
            acc    <= add_sum;
            sticky <= sticky_nxt;
            count  <= count_nxt;
            if (in_last) begin
                out_sum   <= add_sum;
                out_carry <= sticky_nxt;
                out_count <= count_nxt;
            end
        end
    end

endmodule
